muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 39 +++
 rtl/muldiv_div_iter.sv | 96 +++++++++
 rtl/muldiv_unit.sv | 206 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Purpose  : Shared types and constants for the RISC-V M-extension
//            multiply/divide unit: FSM state encoding, funct_3 operation
//            codes and operand-signedness decode helpers.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [2:0] c_f3_mul    = 3'b000;
    localparam logic [2:0] c_f3_mulh   = 3'b001;
    localparam logic [2:0] c_f3_mulhsu = 3'b010;
    localparam logic [2:0] c_f3_mulhu  = 3'b011;
    localparam logic [2:0] c_f3_div    = 3'b100;
    localparam logic [2:0] c_f3_divu   = 3'b101;
    localparam logic [2:0] c_f3_rem    = 3'b110;
    localparam logic [2:0] c_f3_remu   = 3'b111;

    // rs1 is treated as two's complement for these operations
    function automatic logic f3_a_signed(input logic [2:0] f3);
        return (f3 == c_f3_mulh) || (f3 == c_f3_mulhsu) ||
               (f3 == c_f3_div)  || (f3 == c_f3_rem);
    endfunction

    // rs2 is treated as two's complement for these operations
    function automatic logic f3_b_signed(input logic [2:0] f3);
        return (f3 == c_f3_mulh) || (f3 == c_f3_div) || (f3 == c_f3_rem);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_div_iter
// Purpose  : Iterative restoring divider, one quotient bit per clock.
//            Divides operand magnitudes over XLEN cycles, then applies the
//            quotient sign (sign(a) ^ sign(b)) and remainder sign (sign(a))
//            for signed operations.
// Ports    : clk, rst_n (sync, active-low)
//            i_start     - load operands and begin (one-cycle pulse)
//            i_signed    - operands are two's complement
//            i_dividend  - rs1
//            i_divisor   - rs2 (must be non-zero; zero is handled upstream)
//            o_done      - high from completion until the next i_start
//            o_quotient  - signed-corrected quotient
//            o_remainder - signed-corrected remainder
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_div_iter
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic            i_signed,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_done,
    output logic [XLEN-1:0] o_quotient,
    output logic [XLEN-1:0] o_remainder
);

    localparam int              c_cw   = $clog2(XLEN);
    localparam logic [c_cw-1:0] c_last = c_cw'(XLEN - 1);

    logic            r_active;
    logic            r_done;
    logic [c_cw-1:0] r_cnt;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;      // dividend bits shift out, quotient bits shift in
    logic [XLEN-1:0] r_divisor;
    logic            r_q_neg;
    logic            r_r_neg;

    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN:0]   w_shift;
    logic            w_ge;
    logic [XLEN-1:0] w_diff;

    assign w_a_neg = i_signed & i_dividend[XLEN-1];
    assign w_b_neg = i_signed & i_divisor[XLEN-1];

    // Partial remainder after bringing down the next dividend bit
    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_ge    = (w_shift >= {1'b0, r_divisor});
    // Only used when w_ge, where the true difference is below the divisor
    assign w_diff  = w_shift[XLEN-1:0] - r_divisor;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_active  <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
        end else if (i_start) begin
            r_active  <= 1'b1;
            r_done    <= 1'b0;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= w_a_neg ? -i_dividend : i_dividend;
            r_divisor <= w_b_neg ? -i_divisor  : i_divisor;
            r_q_neg   <= w_a_neg ^ w_b_neg;
            r_r_neg   <= w_a_neg;
        end else if (r_active) begin
            r_rem <= w_ge ? w_diff : w_shift[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], w_ge};
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_last) begin
                r_active <= 1'b0;
                r_done   <= 1'b1;
            end
        end
    end

    assign o_done      = r_done;
    assign o_quotient  = r_q_neg ? -r_quo : r_quo;
    assign o_remainder = r_r_neg ? -r_rem : r_rem;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : RISC-V M-extension multiply/divide unit. Iterative shift-add
//            multiplier (XLEN cycles) and, when MULDIV_DIV_EN is defined, an
//            iterative restoring divider with a fast path for divide-by-zero
//            and signed overflow. Without MULDIV_DIV_EN, divide/remainder
//            requests complete with result 0 and no divider is built.
// Ports    : clk, rst_n (sync, active-low)
//            in_valid/in_ready   - request handshake (ready only in IDLE)
//            funct_3, op_a, op_b - operation and operands, captured on accept
//            out_valid/out_ready - result handshake
//            result              - operation result, held while in DONE
//            busy                - high in every state except IDLE
// Config   : MULDIV_DIV_EN - build the divider
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct_3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int              c_cw        = $clog2(XLEN + 1);
    localparam logic [c_cw-1:0] c_mul_steps = c_cw'(XLEN);

    state_e            r_state;
    logic              r_in_ready;
    logic              r_busy;
    logic              r_out_valid;
    logic [XLEN-1:0]   r_result;
    logic [2:0]        r_f3;
    logic [XLEN-1:0]   r_mcand;
    logic [2*XLEN-1:0] r_prod;     // {accumulator, remaining multiplier bits}
    logic [c_cw-1:0]   r_cnt;
    logic              r_neg;

    logic              w_accept;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic [XLEN-1:0]   w_addend;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_mul_res;

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_a_neg  = f3_a_signed(funct_3) && op_a[XLEN-1];
    assign w_b_neg  = f3_b_signed(funct_3) && op_b[XLEN-1];
    assign w_mag_a  = w_a_neg ? -op_a : op_a;
    assign w_mag_b  = w_b_neg ? -op_b : op_b;

    // One shift-add step: add the multiplicand when the current multiplier
    // LSB is set, then shift the whole product right by one.
    assign w_addend   = r_prod[0] ? r_mcand : '0;
    assign w_sum      = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, w_addend};
    assign w_prod_fix = r_neg ? -r_prod : r_prod;
    assign w_mul_res  = (r_f3 == c_f3_mul) ? w_prod_fix[XLEN-1:0]
                                           : w_prod_fix[2*XLEN-1:XLEN];

`ifdef MULDIV_DIV_EN
    localparam logic [XLEN-1:0] c_most_neg = {1'b1, {(XLEN-1){1'b0}}};

    logic            w_div_signed;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic            w_div_fast;
    logic [XLEN-1:0] w_fast_res;
    logic            w_div_start;
    logic            w_div_done;
    logic [XLEN-1:0] w_div_quo;
    logic [XLEN-1:0] w_div_rem;

    // funct_3[1] selects remainder, funct_3[0] selects unsigned
    assign w_div_signed = ~funct_3[0];
    assign w_div_zero   = (op_b == '0);
    assign w_div_ovf    = w_div_signed && (op_a == c_most_neg) && (op_b == '1);
    assign w_div_fast   = w_div_zero || w_div_ovf;
    assign w_fast_res   = w_div_zero ? (funct_3[1] ? op_a : '1)
                                     : (funct_3[1] ? '0   : op_a);
    assign w_div_start  = w_accept && funct_3[2] && !w_div_fast;

    muldiv_div_iter #(
        .XLEN (XLEN)
    ) u_div_iter (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_div_start),
        .i_signed    (w_div_signed),
        .i_dividend  (op_a),
        .i_divisor   (op_b),
        .o_done      (w_div_done),
        .o_quotient  (w_div_quo),
        .o_remainder (w_div_rem)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_f3        <= '0;
            r_mcand     <= '0;
            r_prod      <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_f3       <= funct_3;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (!funct_3[2]) begin
                            r_state <= S_MUL;
                            r_mcand <= w_mag_a;
                            r_prod  <= {{XLEN{1'b0}}, w_mag_b};
                            r_cnt   <= '0;
                            r_neg   <= w_a_neg ^ w_b_neg;
                        end else begin
`ifdef MULDIV_DIV_EN
                            if (w_div_fast) begin
                                // Result is ready now; out_valid follows
                                // on the first DONE cycle.
                                r_state  <= S_DONE;
                                r_result <= w_fast_res;
                            end else begin
                                r_state <= S_DIV;
                            end
`else
                            r_state  <= S_DONE;
                            r_result <= '0;
`endif
                        end
                    end
                end

                S_MUL: begin
                    if (r_cnt == c_mul_steps) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_mul_res;
                    end else begin
                        r_prod <= {w_sum, r_prod[XLEN-1:1]};
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end

                S_DIV: begin
`ifdef MULDIV_DIV_EN
                    if (w_div_done) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= r_f3[1] ? w_div_rem : w_div_quo;
                    end
`else
                    // Unreachable without a divider; recover to IDLE
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b1;
`endif
                end

                S_DONE: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Self-checking bench for muldiv_unit (XLEN=32). Table of directed
//            vectors with hand-computed results and latencies, plus sequences
//            for back-pressure, back-to-back issue and reset mid-operation.
//            Divide expectations follow MULDIV_DIV_EN (result 0, latency 1
//            when the divider is not built).
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int XLEN = 32;

`ifdef MULDIV_DIV_EN
    localparam bit c_div_en = 1'b1;
`else
    localparam bit c_div_en = 1'b0;
`endif

    localparam logic [2:0] c_mul    = 3'b000;
    localparam logic [2:0] c_mulh   = 3'b001;
    localparam logic [2:0] c_mulhsu = 3'b010;
    localparam logic [2:0] c_mulhu  = 3'b011;
    localparam logic [2:0] c_div    = 3'b100;
    localparam logic [2:0] c_divu   = 3'b101;
    localparam logic [2:0] c_rem    = 3'b110;
    localparam logic [2:0] c_remu   = 3'b111;
    localparam int         c_nvec   = 24;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct_3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    int checks   = 0;
    int failures = 0;
    int lat;
    int stale;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [c_nvec];

    always #5 clk = ~clk;

    muldiv_unit #(
        .XLEN (XLEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct_3   (funct_3),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Count edges from the accepting edge until out_valid, bounded
    task automatic wait_result(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Issue one request with out_ready high; operands are scrambled while
    // busy to confirm they are ignored after capture.
    task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int n;
        chk({nm, ".in_ready"}, {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        funct_3  = f3;
        op_a     = a;
        op_b     = b;
        @(posedge clk); #1;
        funct_3 = ~f3;
        op_a    = ~a;
        op_b    = b ^ 32'h5A5A_0001;
        wait_result(n);
        in_valid = 1'b0;
        chk({nm, ".latency"}, n, exp_lat);
        chk({nm, ".result"}, result, exp_res);
        @(posedge clk); #1;
        chk({nm, ".released"}, {30'b0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        vecs[0]  = '{c_mul,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{c_mulh,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        vecs[2]  = '{c_mulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[3]  = '{c_mulhsu, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33};
        vecs[4]  = '{c_mulh,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 33};
        vecs[5]  = '{c_mulh,   32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 33};
        vecs[6]  = '{c_mul,    32'h1234_5678, 32'h10,        32'h2345_6780, 33};
        vecs[7]  = '{c_mulhsu, 32'd2,         32'hFFFF_FFFF, 32'd1,         33};
        vecs[8]  = '{c_mulhu,  32'h8000_0000, 32'd4,         32'd2,         33};
        vecs[9]  = '{c_divu,   32'd100,       32'd7,         32'd14,        33};
        vecs[10] = '{c_remu,   32'd100,       32'd7,         32'd2,         33};
        vecs[11] = '{c_div,    32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 33};
        vecs[12] = '{c_rem,    32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 33};
        vecs[13] = '{c_div,    32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 33};
        vecs[14] = '{c_rem,    32'd100,       32'hFFFF_FFF9, 32'd2,         33};
        vecs[15] = '{c_div,    32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[16] = '{c_rem,    32'd5,         32'd0,         32'd5,         1};
        vecs[17] = '{c_divu,   32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[18] = '{c_remu,   32'd5,         32'd0,         32'd5,         1};
        vecs[19] = '{c_div,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[20] = '{c_rem,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
        vecs[21] = '{c_divu,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33};
        vecs[22] = '{c_remu,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
        vecs[23] = '{c_mul,    32'd0,         32'hFFFF_FFFF, 32'd0,         33};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        funct_3   = 3'b000;
        op_a      = '0;
        op_b      = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset.in_ready",  {31'b0, in_ready},  32'd1);
        chk("reset.out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset.busy",      {31'b0, busy},      32'd0);
        chk("reset.result",    result,             32'd0);

        // Directed vector table
        for (int i = 0; i < c_nvec; i++) begin
            logic [31:0] e;
            int          l;
            e = vecs[i].exp;
            l = vecs[i].lat;
            if (vecs[i].f3[2] && !c_div_en) begin
                e = 32'd0;
                l = 1;
            end
            run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, e, l);
        end

        // Back-pressure in DONE, then back-to-back request
        out_ready = 1'b0;
        in_valid  = 1'b1;
        funct_3   = c_mul;
        op_a      = 32'd3;
        op_b      = 32'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(lat);
        chk("bp.latency", lat, 33);
        for (int i = 0; i < 5; i++) begin
            chk("bp.result",    result,             32'd12);
            chk("bp.in_ready",  {31'b0, in_ready},  32'd0);
            chk("bp.out_valid", {31'b0, out_valid}, 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        funct_3   = c_mulhu;
        op_a      = 32'hFFFF_FFFF;
        op_b      = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        chk("b2b.idle_outv",  {31'b0, out_valid}, 32'd0);
        chk("b2b.idle_ready", {31'b0, in_ready},  32'd1);
        chk("b2b.idle_busy",  {31'b0, busy},      32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b.accepted", {30'b0, busy, in_ready}, 32'd2);
        wait_result(lat);
        chk("b2b.latency", lat, 33);
        chk("b2b.result", result, 32'hFFFF_FFFE);
        @(posedge clk); #1;

        // Reset at iteration 10 of a multiply
        in_valid = 1'b1;
        funct_3  = c_mul;
        op_a     = 32'd7;
        op_b     = 32'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rstmul.out_valid", {31'b0, out_valid}, 32'd0);
        chk("rstmul.busy",      {31'b0, busy},      32'd0);
        chk("rstmul.in_ready",  {31'b0, in_ready},  32'd1);
        chk("rstmul.result",    result,             32'd0);
        stale = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid || busy) stale++;
        end
        chk("rstmul.no_stale", stale, 0);

        // Reset while holding a result in DONE
        out_ready = 1'b0;
        in_valid  = 1'b1;
        funct_3   = c_mul;
        op_a      = 32'd2;
        op_b      = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(lat);
        chk("rstdone.result_before", result, 32'd6);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        chk("rstdone.out_valid", {31'b0, out_valid}, 32'd0);
        chk("rstdone.result",    result,             32'd0);
        @(posedge clk); #1;
        chk("rstdone.in_ready",  {31'b0, in_ready},  32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
